// File: rtl/wide_add_seq.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per cycle, LSB first.
// Optional subtract mode (op_sub port) enabled by defining WIDE_ADD_SEQ_SUB_EN.
module wide_add_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned CntW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic [CHUNK:0]    slice_sum;
  logic [WIDTH-1:0]  acc_shift;
  logic [WIDTH-1:0]  b_load;
  logic              carry_load;

  assign slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

  // New slice enters at the MSB end so the accumulator is aligned after NCH shifts.
  assign acc_shift = (acc_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

`ifdef WIDE_ADD_SEQ_SUB_EN
  assign b_load     = op_sub ? ~b : b;
  assign carry_load = op_sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_shift;
        carry_d = slice_sum[CHUNK];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          s_d     = acc_shift;
          cout_d  = slice_sum[CHUNK];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign s    = s_q;
  assign cout = cout_q;

endmodule
